// File: rtl/genesis_pad_poller.sv
// Genesis 3-button pad poller: drives SEL through eight settle phases per poll,
// samples two data words, validates them and publishes the decoded buttons.
module genesis_pad_poller #(
  parameter int unsigned SETTLE      = 16,
  parameter int unsigned POLL_PERIOD = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] pins,
  output logic       sel,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int unsigned SW = $clog2(SETTLE);
  localparam int unsigned PW = $clog2(POLL_PERIOD);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(POLL_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [PW-1:0] period_q, period_d;
  logic [5:0]    sync1_q, sync2_q;
  logic [5:0]    word_a_q, word_a_d;
  logic [5:0]    word_b_q, word_b_d;
  logic          sel_q, sel_d;
  logic [7:0]    buttons_q, buttons_d;
  logic [7:0]    pressed_q, pressed_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [7:0]    decoded;
  logic          consistent;

  // Two-flop synchronizer; idle level of the pad lines is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      settle_q  <= '0;
      period_q  <= '0;
      word_a_q  <= '1;
      word_b_q  <= '1;
      sel_q     <= 1'b0;
      buttons_q <= '0;
      pressed_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      settle_q  <= settle_d;
      period_q  <= period_d;
      word_a_q  <= word_a_d;
      word_b_q  <= word_b_d;
      sel_q     <= sel_d;
      buttons_q <= buttons_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Decode the captured words (active-low) into {st,c,b,a,rg,lf,dw,up}.
  always_comb begin
    decoded    = ~{word_a_q[0], word_b_q[0], word_b_q[1], word_a_q[1],
                   word_b_q[2], word_b_q[3], word_b_q[4], word_b_q[5]};
    consistent = (word_a_q[5:4] == word_b_q[5:4]) && (word_a_q[3:2] == 2'b11);
  end

  // Next-state logic: poll sequencing, phase timing, capture and result update.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    settle_d  = settle_q;
    period_d  = (period_q == '0) ? '0 : period_q - PW'(1);
    word_a_d  = word_a_q;
    word_b_d  = word_b_q;
    buttons_d = buttons_q;
    pressed_d = '0;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if ((period_q == '0) && enable) begin
          state_d  = RUN;
          phase_d  = 3'd0;
          settle_d = '0;
          period_d = PERIOD_LOAD;
        end
      end
      RUN: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          phase_d  = phase_q + 3'd1;
          if (phase_q == 3'd0) word_a_d = sync2_q;
          if (phase_q == 3'd1) word_b_d = sync2_q;
          if (phase_q == 3'd7) state_d = DONE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = 3'd0;
        if (consistent) begin
          buttons_d = decoded;
          pressed_d = decoded & ~buttons_q;
          valid_d   = 1'b1;
        end else begin
          err_d     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 3'd0;
      end
    endcase

    sel_d  = (state_d == RUN) && phase_d[0];
    busy_d = (state_d != IDLE);
  end

  assign sel     = sel_q;
  assign buttons = buttons_q;
  assign pressed = pressed_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_genesis_pad_poller.sv
// Directed bench for genesis_pad_poller with a behavioural 3-button pad.
`timescale 1ns/1ps
module tb_genesis_pad_poller;

  localparam int unsigned SETTLE      = 16;
  localparam int unsigned POLL_PERIOD = 200;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [5:0] pins;
  logic       sel;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       valid;
  logic       err;
  logic       busy;

  // Pad emulation: held = {st,c,b,a,rg,lf,dw,up}, 1 = pressed
  logic [7:0] held;
  logic       force_p3;
  logic [5:0] pad;
  int         cyc;
  int         checks;
  int         errors;

  genesis_pad_poller #(.SETTLE(SETTLE), .POLL_PERIOD(POLL_PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pins(pins), .sel(sel),
    .buttons(buttons), .pressed(pressed), .valid(valid), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SEL low: {up,dw,0,0,a,st}; SEL high: {up,dw,lf,rg,b,c}; lines are active-low.
  always_comb begin
    if (sel == 1'b0) pad = ~{held[0], held[1], 1'b0, 1'b0, held[4], held[7]};
    else             pad = ~{held[0], held[1], held[2], held[3], held[5], held[6]};
    pins = force_p3 ? (pad & 6'b110111) : pad;
  end

  // Wait for a poll to start and follow it to completion, recording observations.
  task automatic run_poll(input int drop_at, output int start_cyc, output int lat,
                          output int tog, output int rises, output logic v,
                          output logic e, output logic [7:0] pr,
                          output logic [7:0] bt, output logic v_after);
    int   n;
    logic ps;
    n = 0; lat = 0; tog = 0; rises = 0; start_cyc = 0;
    v = 1'bx; e = 1'bx; pr = 'x; bt = 'x; v_after = 1'bx;
    while (busy !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL poll_start: busy=%b required 1 within 1000 cycles", busy);
    end else begin
      start_cyc = cyc;
      ps = sel;
      while (busy === 1'b1 && lat < 400) begin
        @(negedge clk);
        lat++;
        if (sel !== ps) begin
          tog++;
          if (sel === 1'b1) rises++;
        end
        ps = sel;
        if (lat == drop_at) enable = 1'b0;
      end
      v = valid; e = err; pr = pressed; bt = buttons;
      @(negedge clk);
      v_after = valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; held = '0; force_p3 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sel !== 1'b0)     begin errors++; $display("FAIL reset_sel: got %b required 0", sel); end
    checks++; if (buttons !== 8'h0) begin errors++; $display("FAIL reset_buttons: got %h required 00", buttons); end
    checks++; if (pressed !== 8'h0) begin errors++; $display("FAIL reset_pressed: got %h required 00", pressed); end
    checks++; if ({valid, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {valid, err, busy}); end
  endtask

  task automatic test_idle_poll(output int s1);
    int lat, tog, rises; logic v, e, va; logic [7:0] pr, bt;
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_poll_start: busy=%b required 1", busy); end
    run_poll(-1, s1, lat, tog, rises, v, e, pr, bt, va);
    checks++; if (lat !== 129)  begin errors++; $display("FAIL poll_length: got %0d required 129", lat); end
    checks++; if (tog !== 8)    begin errors++; $display("FAIL sel_toggles: got %0d required 8", tog); end
    checks++; if (rises !== 4)  begin errors++; $display("FAIL sel_rises: got %0d required 4", rises); end
    checks++; if ({v, e} !== 2'b10) begin errors++; $display("FAIL idle_valid_err: got %b required 10", {v, e}); end
    checks++; if (bt !== 8'h00) begin errors++; $display("FAIL idle_buttons: got %h required 00", bt); end
    checks++; if (va !== 1'b0)  begin errors++; $display("FAIL valid_width: got %b required 0", va); end
  endtask

  task automatic test_period(input int s1);
    int s2, lat, tog, rises; logic v, e, va; logic [7:0] pr, bt;
    run_poll(-1, s2, lat, tog, rises, v, e, pr, bt, va);
    checks++; if (s2 - s1 !== POLL_PERIOD) begin errors++; $display("FAIL poll_period: got %0d required %0d", s2 - s1, POLL_PERIOD); end
  endtask

  task automatic test_a_start();
    int s, lat, tog, rises; logic v, e, va; logic [7:0] pr, bt;
    held = 8'h90;  // st at bit 7, a at bit 4
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if (bt !== 8'h90) begin errors++; $display("FAIL a_start_buttons: got %h required 90", bt); end
    checks++; if (pr !== 8'h90) begin errors++; $display("FAIL a_start_pressed1: got %h required 90", pr); end
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if (pr !== 8'h00) begin errors++; $display("FAIL a_start_pressed2: got %h required 00", pr); end
    checks++; if (bt !== 8'h90) begin errors++; $display("FAIL a_start_hold: got %h required 90", bt); end
  endtask

  task automatic test_up_b_release();
    int s, lat, tog, rises; logic v, e, va; logic [7:0] pr, bt;
    held = 8'h21;
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if (bt !== 8'h21) begin errors++; $display("FAIL up_b_buttons: got %h required 21", bt); end
    checks++; if (pr !== 8'h21) begin errors++; $display("FAIL up_b_pressed: got %h required 21", pr); end
    held = 8'h00;
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if (bt !== 8'h00) begin errors++; $display("FAIL release_buttons: got %h required 00", bt); end
    checks++; if (pr !== 8'h00) begin errors++; $display("FAIL release_pressed: got %h required 00", pr); end
  endtask

  task automatic test_err();
    int s, lat, tog, rises; logic v, e, va; logic [7:0] pr, bt;
    held = 8'h20;
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if (bt !== 8'h20) begin errors++; $display("FAIL err_setup_buttons: got %h required 20", bt); end
    held = 8'h00; force_p3 = 1'b1;
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    force_p3 = 1'b0;
    checks++; if ({v, e} !== 2'b01) begin errors++; $display("FAIL err_flags: got valid,err=%b required 01", {v, e}); end
    checks++; if (bt !== 8'h20) begin errors++; $display("FAIL err_buttons_hold: got %h required 20", bt); end
    checks++; if (pr !== 8'h00) begin errors++; $display("FAIL err_pressed: got %h required 00", pr); end
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if ({v, e, bt} !== {2'b10, 8'h00}) begin errors++; $display("FAIL after_err: got v,e,buttons=%b%b %h required 10 00", v, e, bt); end
  endtask

  task automatic test_enable_drop();
    int s, lat, tog, rises, act; logic v, e, va, ps; logic [7:0] pr, bt;
    run_poll(56, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if ({v, e, lat} !== {2'b10, 32'd129}) begin errors++; $display("FAIL drop_poll: got v,e=%b%b len=%0d required 10 len=129", v, e, lat); end
    act = 0; ps = sel;
    repeat (2 * POLL_PERIOD) begin
      @(negedge clk);
      if (sel !== ps || busy !== 1'b0) act++;
      ps = sel;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL drop_quiet: got %0d active cycles required 0", act); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reenable_start: busy=%b required 1", busy); end
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
  endtask

  task automatic test_reset_mid();
    int n, s, lat, tog, rises, bad; logic v, e, va; logic [7:0] pr, bt;
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    repeat (88) @(negedge clk);
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL phase5_sel: got %b required 1", sel); end
    rst_n = 1'b0;
    #1;
    checks++; if ({sel, busy} !== 2'b00) begin errors++; $display("FAIL async_reset: sel,busy=%b required 00", {sel, busy}); end
    bad = 0;
    repeat (3) begin @(negedge clk); if (valid !== 1'b0 || err !== 1'b0) bad++; end
    rst_n = 1'b1;
    @(negedge clk);
    if (valid !== 1'b0 || err !== 1'b0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_no_pulse: got %0d pulse cycles required 0", bad); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_start: busy=%b required 1", busy); end
    run_poll(-1, s, lat, tog, rises, v, e, pr, bt, va);
    checks++; if ({v, lat} !== {1'b1, 32'd129}) begin errors++; $display("FAIL post_reset_poll: got v=%b len=%0d required 1 len=129", v, lat); end
  endtask

  initial begin
    int s1;
    cyc = 0; checks = 0; errors = 0;
    test_reset();
    test_idle_poll(s1);
    test_period(s1);
    test_a_start();
    test_up_b_release();
    test_err();
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
